// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised sync FIFO.
// Holds default geometry and the width helper.
package fifo_pkg;

  localparam int DEF_DATA_W = 10;
  localparam int DEF_DEPTH  = 16;

  // Ceiling log2 used for pointer and occupancy widths.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W RAM, synchronous write, registered read port.
// FIFO_FWFT_EN switches the read port to combinational.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = clog2(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef FIFO_FWFT_EN
  logic unused_ok;
  assign unused_ok = ^{rst, re};
  assign rdata = mem[raddr];
`else
  // Output register: loads on an accepted read, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO: pointers, occupancy, flags, sticky errors.
// FIFO_FWFT_EN selects first-word-fall-through output.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      in,
  input  logic                   wr_en,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      out,
  output logic                   out_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [clog2(DEPTH):0]  count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr_acc;
  logic          rd_acc;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  // A read frees a slot, so a full FIFO still takes a paired write.
  assign wr_acc = wr_en && (!full || rd_en);
  assign rd_acc = rd_en && !empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + AW'(1);
      if (rd_acc) rptr <= rptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full && !rd_en) overflow  <= 1'b1;
      if (rd_en && empty)          underflow <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  assign out_valid = !empty;
`else
  // Valid strobe trails an accepted read by one cycle.
  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= rd_acc;
  end
`endif

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (in),
    .re    (rd_acc),
    .raddr (rptr),
    .rdata (out)
  );

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo (DATA_W=10, DEPTH=16).
// Stimulus queues expected reads; a negedge monitor checks them.
module tb_param_sync_fifo;

  localparam int DW    = 10;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          out_valid;
  logic          full;
  logic          empty;
  logic          af;
  logic          ae;
  logic [4:0]    count;
  logic          ovf;
  logic          unf;

  int n_pass = 0;
  int n_tot  = 0;

  logic [DW-1:0] model[$];
  logic [DW-1:0] exp_q[$];
  bit            mov;
  bit            mun;

  always #5 clk = ~clk;

  param_sync_fifo #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in           (din),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .out          (dout),
    .out_valid    (out_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (af),
    .almost_empty (ae),
    .count        (count),
    .overflow     (ovf),
    .underflow    (unf)
  );

  task automatic chk(input string nm, input int act, input int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  nm, act, req, $time);
  endtask

  task automatic chk_state();
    int sz;
    sz = model.size();
    chk("count", int'(count), sz);
    chk("full", int'(full), int'(sz == DEPTH));
    chk("empty", int'(empty), int'(sz == 0));
    chk("almost_full", int'(af), int'(sz >= 14));
    chk("almost_empty", int'(ae), int'(sz <= 2));
    chk("overflow", int'(ovf), int'(mov));
    chk("underflow", int'(unf), int'(mun));
  endtask

  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r);
    int sz;
    bit wa;
    bit ra;
    sz = model.size();
    wa = w && (sz != DEPTH || r);
    ra = r && (sz != 0);
    if (w && sz == DEPTH && !r) mov = 1'b1;
    if (r && sz == 0) mun = 1'b1;
    wr_en = w;
    rd_en = r;
    din   = d;
    if (ra) exp_q.push_back(model.pop_front());
    if (wa) model.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk_state();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model.delete();
    exp_q.delete();
    mov = 1'b0;
    mun = 1'b0;
    chk_state();
`ifndef FIFO_FWFT_EN
    chk("rst_out", int'(dout), 0);
`endif
    chk("rst_out_valid", int'(out_valid), 0);
  endtask

  // Monitor: every presented word must match the scoreboard head.
  always @(negedge clk) begin
`ifdef FIFO_FWFT_EN
    if (out_valid && rd_en) begin
`else
    if (out_valid) begin
`endif
      if (exp_q.size() == 0) chk("spurious_out_valid", 1, 0);
      else chk("rd_data", int'(dout), int'(exp_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    mov   = 1'b0;
    mun   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Fill 0x001..0x010, then overflow attempt.
    for (int i = 1; i <= 16; i++) cyc(1'b1, DW'(i), 1'b0);
    cyc(1'b1, 10'h3FF, 1'b0);

    // Drain in order, then underflow attempt.
    for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
`ifndef FIFO_FWFT_EN
    chk("out_hold", int'(dout), 'h010);
    chk("idle_out_valid", int'(out_valid), 0);
`endif

    // Wrap-around.
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, DW'(10'h100 + i), 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 12; i++) cyc(1'b1, DW'(10'h200 + i), 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, '0, 1'b1);

    // Steady simultaneous traffic at count 5.
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(10'h040 + i), 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, DW'(10'h050 + i), 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1);

    // Simultaneous at full: no overflow.
    for (int i = 0; i < 16; i++) cyc(1'b1, DW'(10'h080 + i), 1'b0);
    cyc(1'b1, 10'h123, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1);

    // Simultaneous at empty: write only, underflow.
    cyc(1'b1, 10'h155, 1'b1);
    cyc(1'b0, '0, 1'b1);

    // Reset while holding 7 words.
    for (int i = 0; i < 7; i++) cyc(1'b1, DW'(10'h300 + i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    do_reset();

    // Single word into an empty FIFO.
    cyc(1'b1, 10'h2AA, 1'b0);
`ifdef FIFO_FWFT_EN
    chk("fwft_out", int'(dout), 'h2AA);
    chk("fwft_valid", int'(out_valid), 1);
`else
    chk("no_read_valid", int'(out_valid), 0);
`endif
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);

    chk("exp_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
